// File: rtl/dec_key_debounce.sv
// dec_key_debounce: synchronizes and debounces ten decimal key lines into a held one-hot code.
// Multi-key presses are rejected with an error pulse.
module dec_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] key_raw,
  output logic [9:0] y,
  output logic       key_valid,
  output logic       key_err,
  output logic       busy
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] DEB_PRESS   = 2'd1;
  localparam logic [1:0] PRESSED     = 2'd2;
  localparam logic [1:0] DEB_RELEASE = 2'd3;

  logic [1:0]    state;
  logic [9:0]    meta, key_sync, cand;
  logic [CW-1:0] cnt;
  logic          held, at_last, one_hot;

  assign held    = key_sync != 10'd0;
  assign at_last = cnt == LAST;
  assign one_hot = (cand & (cand - 10'd1)) == 10'd0;
  assign busy    = state != IDLE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta      <= '0;
      key_sync  <= '0;
      cand      <= '0;
      cnt       <= '0;
      y         <= '0;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
      state     <= IDLE;
    end else begin
      meta      <= key_raw;
      key_sync  <= meta;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
      case (state)
        IDLE: if (held) begin
          cand  <= key_sync;
          cnt   <= '0;
          state <= DEB_PRESS;
        end
        // a bounce on the terminal-count edge wins over acceptance
        DEB_PRESS: if (!held) state <= IDLE;
          else if (key_sync != cand) begin
            cand <= key_sync;
            cnt  <= '0;
          end else if (!at_last) cnt <= cnt + 1'b1;
          else begin
            state <= PRESSED;
            if (one_hot) begin
              y         <= cand;
              key_valid <= 1'b1;
            end else key_err <= 1'b1;
          end
        PRESSED: if (!held) begin
          cnt   <= '0;
          state <= DEB_RELEASE;
        end
        DEB_RELEASE: if (held) state <= PRESSED;
          else if (at_last) state <= IDLE;
          else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dec_key_debounce.sv
// tb_dec_key_debounce: directed stimulus with a pulse scoreboard for dec_key_debounce (DEBOUNCE_CYCLES = 4).
module tb_dec_key_debounce;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] key_raw;
  logic [9:0] y;
  logic       key_valid, key_err, busy;
  int         checks = 0;
  int         failures = 0;

  typedef struct {
    logic       err;
    logic [9:0] y;
    int         digit;
  } exp_t;
  exp_t q[$];

  dec_key_debounce #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .key_raw(key_raw),
    .y(y), .key_valid(key_valid), .key_err(key_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic err, input logic [9:0] yv, input int digit);
    exp_t e;
    e.err = err;
    e.y = yv;
    e.digit = digit;
    q.push_back(e);
  endtask

  function automatic int enc(input logic [9:0] v);
    int r = -1;
    for (int i = 0; i < 10; i++) if (v[i]) r = i;
    return r;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1) begin
      chk("exclusive", {31'd0, key_valid & key_err}, 32'd0);
      chk("y_onehot", {31'd0, (y & (y - 10'd1)) == 10'd0}, 32'd1);
      if (key_valid || key_err) begin
        if (q.size() == 0) chk("unexpected_pulse", {30'd0, key_err, key_valid}, 32'd0);
        else begin
          e = q.pop_front();
          chk("pulse_kind", {31'd0, key_err}, {31'd0, e.err});
          chk("pulse_y", {22'd0, y}, {22'd0, e.y});
          if (!e.err) chk("enc_digit", enc(y), e.digit);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    key_raw = 10'h008;
    tick(3);
    chk("rst_y", {22'd0, y}, 32'd0);
    chk("rst_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_err", {31'd0, key_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    push(1'b0, 10'h008, 3);
    rst_n = 1'b1;
    tick(6);
    chk("lat_y_early", {22'd0, y}, 32'd0);
    chk("lat_valid_early", {31'd0, key_valid}, 32'd0);
    chk("lat_busy", {31'd0, busy}, 32'd1);
    tick(1);
    chk("lat_y", {22'd0, y}, 32'h008);
    chk("lat_valid", {31'd0, key_valid}, 32'd1);
    key_raw = '0;
    tick(12);
    chk("rel_idle", {31'd0, busy}, 32'd0);
    chk("rel_hold", {22'd0, y}, 32'h008);
    for (int i = 0; i < 10; i++) begin
      push(1'b0, 10'(1 << i), i);
      key_raw = 10'(1 << i);
      tick(10);
      key_raw = '0;
      tick(12);
      chk("sweep_hold", {22'd0, y}, 32'(1 << i));
    end
    push(1'b0, 10'h020, 5);
    for (int i = 0; i < 2; i++) begin
      key_raw = 10'h020;
      tick(2);
      key_raw = '0;
      tick(2);
    end
    key_raw = 10'h020;
    tick(12);
    chk("bounce_y", {22'd0, y}, 32'h020);
    key_raw = '0;
    tick(2);
    key_raw = 10'h020;
    tick(1);
    key_raw = '0;
    tick(3);
    key_raw = 10'h020;
    tick(2);
    key_raw = '0;
    tick(12);
    chk("bounce_rel_idle", {31'd0, busy}, 32'd0);
    push(1'b1, 10'h020, -1);
    key_raw = 10'h041;
    tick(10);
    chk("multi_y", {22'd0, y}, 32'h020);
    key_raw = '0;
    tick(12);
    push(1'b0, 10'h004, 2);
    key_raw = 10'h002;
    tick(3);
    key_raw = 10'h004;
    tick(10);
    chk("change_y", {22'd0, y}, 32'h004);
    key_raw = 10'h00c;
    tick(8);
    chk("added_key_y", {22'd0, y}, 32'h004);
    key_raw = '0;
    tick(12);
    key_raw = 10'h080;
    tick(5);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_y", {22'd0, y}, 32'd0);
    chk("async_busy", {31'd0, busy}, 32'd0);
    chk("async_valid", {31'd0, key_valid}, 32'd0);
    tick(3);
    push(1'b0, 10'h080, 7);
    rst_n = 1'b1;
    tick(10);
    chk("repress_y", {22'd0, y}, 32'h080);
    key_raw = '0;
    tick(12);
    chk("queue_empty", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
